// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM command path: duty width, ramp FSM states
// and a counter-width helper used by the strobe prescalers.
package pwm_pkg;

    localparam int DUTY_W = 7;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DOWN = 2'd1,
        DEAD = 2'd2
    } ramp_state_e;

    // A terminal count of 1 still needs a one-bit register.
    function automatic int cnt_width(input int tc);
        return (tc > 1) ? $clog2(tc) : 1;
    endfunction

endpackage

// File: rtl/e_prescaler.sv
// Counts period strobes from 0 to TC-1 and wraps; tick marks the strobe that
// lands on the terminal count. Used for both the ramp and dead-time counters.
module e_prescaler
    import pwm_pkg::*;
#(
    parameter  int TC = 4,
    localparam int CW = cnt_width(TC)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic e,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(TC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and terminal-strobe detect; clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        tick  = en & e & (cnt_q == LAST);
        if (clr) begin
            cnt_d = '0;
        end else if (en && e) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Rate-limited duty command for the PWM CCR input. Duty moves by STEP once per
// PERIODS_PER_STEP period strobes; a direction reversal ramps to zero and holds
// a dead interval before the bridge direction flips.
module duty_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int W                = DUTY_W,
    parameter int STEP             = 1,
    parameter int PERIODS_PER_STEP = 4,
    parameter int DEAD_PERIODS     = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         E,
    input  logic [W-1:0] TARGET,
    input  logic         DIR_REQ,
    output logic [W-1:0] DUTY,
    output logic         DIR,
    output logic         BUSY
);

    localparam logic [W:0] STEP_X = (W + 1)'(STEP);

    // One ramp move toward goal; the extra bit keeps the clamp test from wrapping.
    function automatic logic [W-1:0] ramp_toward(input logic [W-1:0] cur,
                                                 input logic [W-1:0] goal);
        logic [W:0]   cur_x;
        logic [W:0]   goal_x;
        logic [W-1:0] res;
        cur_x  = {1'b0, cur};
        goal_x = {1'b0, goal};
        res    = cur;
        if (cur_x < goal_x) begin
            if ((cur_x + STEP_X) >= goal_x) begin
                res = goal;
            end else begin
                res = cur + STEP_X[W-1:0];
            end
        end else if (cur_x > goal_x) begin
            if ((goal_x + STEP_X) >= cur_x) begin
                res = goal;
            end else begin
                res = cur - STEP_X[W-1:0];
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

    ramp_state_e  state_q;
    ramp_state_e  state_d;
    logic [W-1:0] duty_q;
    logic [W-1:0] duty_d;
    logic         dir_q;
    logic         dir_d;

    logic         rev_req;
    logic         ramp_tick;
    logic         dead_tick;
    logic         pre_en;
    logic         pre_clr;
    logic         dead_en;
    logic         dead_clr;

    assign rev_req  = (DIR_REQ != dir_q);
    assign pre_en   = (state_q != DEAD);
    assign pre_clr  = (state_q != DEAD) && (state_d == DEAD);
    assign dead_en  = (state_q == DEAD);
    assign dead_clr = (state_q != DEAD);

    e_prescaler #(.TC(PERIODS_PER_STEP)) u_ramp_pre (
        .clk  (CLK),
        .rst  (RST),
        .clr  (pre_clr),
        .en   (pre_en),
        .e    (E),
        .tick (ramp_tick)
    );

    e_prescaler #(.TC(DEAD_PERIODS)) u_dead_cnt (
        .clk  (CLK),
        .rst  (RST),
        .clr  (dead_clr),
        .en   (dead_en),
        .e    (E),
        .tick (dead_tick)
    );

    // Next-state, duty and direction; the reversal-abort check outranks the dead timeout.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        case (state_q)
            RUN: begin
                if (ramp_tick) begin
                    duty_d = ramp_toward(duty_q, TARGET);
                end else begin
                    duty_d = duty_q;
                end
                if (rev_req) begin
                    state_d = (duty_q != {W{1'b0}}) ? DOWN : DEAD;
                end else begin
                    state_d = RUN;
                end
            end
            DOWN: begin
                if (ramp_tick) begin
                    duty_d = ramp_toward(duty_q, {W{1'b0}});
                end else begin
                    duty_d = duty_q;
                end
                if (!rev_req) begin
                    state_d = RUN;
                end else if (duty_q == {W{1'b0}}) begin
                    state_d = DEAD;
                end else begin
                    state_d = DOWN;
                end
            end
            DEAD: begin
                duty_d = '0;
                if (!rev_req) begin
                    state_d = RUN;
                end else if (dead_tick) begin
                    dir_d   = ~dir_q;
                    state_d = RUN;
                end else begin
                    state_d = DEAD;
                end
            end
            default: begin
                state_d = RUN;
                duty_d  = '0;
            end
        endcase
    end

    // State, duty and direction registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            duty_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
        end
    end

    assign DUTY = duty_q;
    assign DIR  = dir_q;
    assign BUSY = (state_q != RUN) | (duty_q != TARGET);

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl: three instances (STEP 1, 4, 16) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_duty_ramp_ctrl;

    localparam int PPS = 4;
    localparam int DP  = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       E;
    logic       DIR_REQ;
    logic [6:0] TARGET;

    logic [6:0] duty_o [3];
    logic       dir_o  [3];
    logic       busy_o [3];

    always #5 CLK = ~CLK;

    duty_ramp_ctrl #(.W(7), .STEP(1), .PERIODS_PER_STEP(PPS), .DEAD_PERIODS(DP)) dut0 (
        .CLK(CLK), .RST(RST), .E(E), .TARGET(TARGET), .DIR_REQ(DIR_REQ),
        .DUTY(duty_o[0]), .DIR(dir_o[0]), .BUSY(busy_o[0]));
    duty_ramp_ctrl #(.W(7), .STEP(4), .PERIODS_PER_STEP(PPS), .DEAD_PERIODS(DP)) dut1 (
        .CLK(CLK), .RST(RST), .E(E), .TARGET(TARGET), .DIR_REQ(DIR_REQ),
        .DUTY(duty_o[1]), .DIR(dir_o[1]), .BUSY(busy_o[1]));
    duty_ramp_ctrl #(.W(7), .STEP(16), .PERIODS_PER_STEP(PPS), .DEAD_PERIODS(DP)) dut2 (
        .CLK(CLK), .RST(RST), .E(E), .TARGET(TARGET), .DIR_REQ(DIR_REQ),
        .DUTY(duty_o[2]), .DIR(dir_o[2]), .BUSY(busy_o[2]));

    // mode: 0 = tracking target, 1 = ramping to zero for reversal, 2 = dead interval
    typedef struct {
        int mode;
        int duty;
        bit dir;
        int pcnt;
        int dcnt;
    } mstate_t;

    mstate_t m [3];
    bit      mvalid = 1'b0;
    int      checks = 0;
    int      failures = 0;
    int      eper = 128;

    function automatic int step_of(input int i);
        case (i)
            0: return 1;
            1: return 4;
            default: return 16;
        endcase
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input bit rst, input bit e,
                                      input int tgt, input bit dreq, input int step);
        mstate_t n;
        int      goal;
        bit      ramp;
        n = s;
        if (rst) begin
            n.mode = 0; n.duty = 0; n.dir = 1'b0; n.pcnt = 0; n.dcnt = 0;
            return n;
        end
        ramp = e && (s.mode != 2) && (((s.pcnt + 1) % PPS) == 0);
        goal = (s.mode == 0) ? tgt : 0;
        if (ramp) begin
            if (s.duty < goal)
                n.duty = (s.duty + step < goal) ? s.duty + step : goal;
            else if (s.duty > goal)
                n.duty = (s.duty - step > goal) ? s.duty - step : goal;
        end
        if (e && s.mode != 2) n.pcnt = s.pcnt + 1;
        if (e && s.mode == 2) n.dcnt = s.dcnt + 1;
        case (s.mode)
            0: if (dreq != s.dir) n.mode = (s.duty != 0) ? 1 : 2;
            1: begin
                if (dreq == s.dir) n.mode = 0;
                else if (s.duty == 0) n.mode = 2;
            end
            default: begin
                n.duty = 0;
                if (dreq == s.dir) n.mode = 0;
                else if (e && (s.dcnt + 1 == DP)) begin
                    n.dir  = ~s.dir;
                    n.mode = 0;
                end
            end
        endcase
        if (n.mode == 2 && s.mode != 2) n.pcnt = 0;
        if (n.mode != 2) n.dcnt = 0;
        return n;
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++)
            m[i] <= mstep(m[i], RST, E, int'(TARGET), DIR_REQ, step_of(i));
        if (RST) mvalid <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_duty%0d", i), 32'(duty_o[i]), 32'(m[i].duty));
            chk($sformatf("model_dir%0d", i), 32'(dir_o[i]), 32'(m[i].dir));
            chk($sformatf("model_busy%0d", i), 32'(busy_o[i]),
                32'((m[i].mode != 0) || (m[i].duty != int'(TARGET))));
        end
    endtask

    // Advance to the next falling edge and compare all instances to the model.
    task automatic cyc();
        @(negedge CLK);
        if (mvalid) cmp_model();
    endtask

    task automatic e_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (eper - 1) cyc();
            E = 1'b1;
            cyc();
            E = 1'b0;
        end
    endtask

    initial begin
        RST = 1'b1; E = 1'b0; DIR_REQ = 1'b0; TARGET = 7'd10;
        cyc();
        RST = 1'b0;
        chk("rst_duty", 32'(duty_o[0]), 32'd0);
        chk("rst_dir", 32'(dir_o[0]), 32'd0);
        chk("rst_busy", 32'(busy_o[0]), 32'd1);

        // ramp up, one step per four strobes
        e_pulses(3);  chk("up_3e", 32'(duty_o[0]), 32'd0);
        e_pulses(1);  chk("up_4e", 32'(duty_o[0]), 32'd1);
        e_pulses(35); chk("up_39e", 32'(duty_o[0]), 32'd9);
        e_pulses(1);  chk("up_40e", 32'(duty_o[0]), 32'd10);
        chk("up_busy", 32'(busy_o[0]), 32'd0);
        chk("up_s4", 32'(duty_o[1]), 32'd10);

        eper = 32;
        TARGET = 7'd3;
        e_pulses(4);  chk("dn_s4_a", 32'(duty_o[1]), 32'd6);
        e_pulses(4);  chk("dn_s4_clamp", 32'(duty_o[1]), 32'd3);
        e_pulses(4);  chk("dn_s4_hold", 32'(duty_o[1]), 32'd3);
        chk("dn_s4_busy", 32'(busy_o[1]), 32'd0);
        e_pulses(16); chk("dn_s1", 32'(duty_o[0]), 32'd3);

        // full reversal from duty 5
        TARGET = 7'd5;
        e_pulses(8);  chk("rev_start", 32'(duty_o[0]), 32'd5);
        DIR_REQ = 1'b1;
        cyc();
        chk("rev_busy", 32'(busy_o[0]), 32'd1);
        chk("rev_dir0", 32'(dir_o[0]), 32'd0);
        e_pulses(19); chk("rev_19e", 32'(duty_o[0]), 32'd1);
        e_pulses(1);  chk("rev_zero", 32'(duty_o[0]), 32'd0);
        chk("rev_zero_dir", 32'(dir_o[0]), 32'd0);
        e_pulses(7);  chk("rev_dead7", 32'(dir_o[0]), 32'd0);
        chk("rev_dead_busy", 32'(busy_o[0]), 32'd1);
        e_pulses(1);  chk("rev_flip", 32'(dir_o[0]), 32'd1);
        chk("rev_flip_duty", 32'(duty_o[0]), 32'd0);
        e_pulses(4);  chk("rev_reramp", 32'(duty_o[0]), 32'd1);
        chk("rev_reramp_busy", 32'(busy_o[0]), 32'd1);
        e_pulses(16); chk("rev_done", 32'(duty_o[0]), 32'd5);
        chk("rev_done_busy", 32'(busy_o[0]), 32'd0);

        // aborted reversal
        RST = 1'b1; DIR_REQ = 1'b0;
        cyc();
        RST = 1'b0;
        chk("ab_rst_dir", 32'(dir_o[0]), 32'd0);
        e_pulses(20); chk("ab_start", 32'(duty_o[0]), 32'd5);
        DIR_REQ = 1'b1;
        e_pulses(8);  chk("ab_mid", 32'(duty_o[0]), 32'd3);
        DIR_REQ = 1'b0;
        cyc();
        chk("ab_dir", 32'(dir_o[0]), 32'd0);
        chk("ab_busy", 32'(busy_o[0]), 32'd1);
        e_pulses(8);  chk("ab_back", 32'(duty_o[0]), 32'd5);
        chk("ab_back_busy", 32'(busy_o[0]), 32'd0);
        chk("ab_back_dir", 32'(dir_o[0]), 32'd0);

        // reversal at zero duty
        TARGET = 7'd0;
        e_pulses(20); chk("z_duty", 32'(duty_o[0]), 32'd0);
        chk("z_busy", 32'(busy_o[0]), 32'd0);
        DIR_REQ = 1'b1;
        cyc();
        chk("z_dead_busy", 32'(busy_o[0]), 32'd1);
        e_pulses(7);  chk("z_dead7", 32'(dir_o[0]), 32'd0);
        e_pulses(1);  chk("z_flip", 32'(dir_o[0]), 32'd1);
        chk("z_flip_busy", 32'(busy_o[0]), 32'd0);

        // reset in the middle of a dead interval
        RST = 1'b1; DIR_REQ = 1'b0;
        cyc();
        RST = 1'b0; DIR_REQ = 1'b1;
        cyc();
        chk("mr_dead_busy", 32'(busy_o[0]), 32'd1);
        e_pulses(3);
        RST = 1'b1; DIR_REQ = 1'b0; TARGET = 7'd127;
        cyc();
        RST = 1'b0;
        chk("mr_duty", 32'(duty_o[0]), 32'd0);
        chk("mr_dir", 32'(dir_o[0]), 32'd0);
        chk("mr_busy", 32'(busy_o[0]), 32'd1);
        e_pulses(3);  chk("mr_pre3", 32'(duty_o[0]), 32'd0);
        e_pulses(1);  chk("mr_pre4", 32'(duty_o[0]), 32'd1);

        // reset with the prescaler part-way through, then saturation
        e_pulses(2);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        e_pulses(3);  chk("ps_restart3", 32'(duty_o[0]), 32'd0);
        e_pulses(1);  chk("ps_restart4", 32'(duty_o[0]), 32'd1);
        chk("sat_first", 32'(duty_o[2]), 32'd16);
        e_pulses(24); chk("sat_112", 32'(duty_o[2]), 32'd112);
        e_pulses(4);  chk("sat_127", 32'(duty_o[2]), 32'd127);
        chk("sat_busy", 32'(busy_o[2]), 32'd0);
        e_pulses(8);  chk("sat_hold", 32'(duty_o[2]), 32'd127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
